opll_reg_writer: RTL and testbench

Host-side register-write sequencer for the OPLL tile. It accepts (register address, data) pairs over a valid/ready handshake and replays each pair as the two-step bus transaction the OPLL bus port expects: an address write with A0=0, then a data write with A0=1. Each step is followed by a programmable settle wait. It sits between a host controller (SPI/UART bridge or sequencer ROM) and the OPLL data bus, A0 and active-high WR pins, on the same master clock.

---
 rtl/opll_reg_writer_pkg.sv | 31 +++
 rtl/opll_reg_writer_fifo.sv | 64 ++++++
 rtl/opll_reg_writer.sv | 183 ++++++++++++++++++
 tb/tb_opll_reg_writer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opll_reg_writer_pkg.sv
// Shared types and defaults for the OPLL register-write sequencer.
package opll_reg_writer_pkg;

   // Sequencer phases; one shared down-counter times every phase except IDLE.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      AWAIT = 3'd2,
      DATA  = 3'd3,
      DWAIT = 3'd4
   } state_t;

   // Default bus timing in clk cycles.
   localparam int DEF_WR_PULSE  = 2;
   localparam int DEF_ADDR_WAIT = 12;
   localparam int DEF_DATA_WAIT = 84;

   // One register write request as seen by the host.
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } req_t;

   // Largest of three timing values; sizes the shared counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/opll_reg_writer_fifo.sv
// Small synchronous request FIFO with show-ahead read data.
// Pushes are ignored when full and pops are ignored when empty, so the
// caller never has to reason about overflow or underflow.
module opll_reg_writer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage write; no reset needed because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rdata = mem[rd_ptr_reg];
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/opll_reg_writer.sv
// OPLL register-write sequencer: turns (addr, data) requests into an
// address write (A0=0) followed by a data write (A0=1), each followed by a
// settle wait with WR low.
// Build option: define OPLL_REG_WRITER_FIFO_EN to add a FIFO_DEPTH-entry
// request queue so the host can post writes while a transaction runs.
module opll_reg_writer
   import opll_reg_writer_pkg::*;
#(
   parameter int WR_PULSE   = DEF_WR_PULSE,
   parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
   parameter int DATA_WAIT  = DEF_DATA_WAIT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_data,
   output logic [7:0] o_din,
   output logic       o_a0,
   output logic       o_wr,
   output logic       o_busy
);

   localparam int CNT_W = $clog2(max3(WR_PULSE, ADDR_WAIT, DATA_WAIT)) + 1;
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(WR_PULSE - 1);
   localparam logic [CNT_W-1:0] AWAIT_LD = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] DWAIT_LD = CNT_W'(DATA_WAIT - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [7:0]       data_reg, data_next;
   logic [7:0]       din_reg, din_next;
   logic             a0_reg, a0_next;
   logic             wr_reg, wr_next;

   // Request source seen by the FSM: FIFO head or the host port directly.
   req_t             src_req;
   logic             req_avail;
   logic             take;

`ifdef OPLL_REG_WRITER_FIFO_EN
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        fifo_push;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [$bits(req_t)-1:0]     fifo_rdata;

   assign o_ready   = !fifo_full && !rst;
   assign fifo_push = i_valid && o_ready;
   assign req_avail = !fifo_empty;
   assign src_req   = req_t'(fifo_rdata);
   assign o_busy    = (state_reg != IDLE) || (fifo_count != '0);

   opll_reg_writer_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(req_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (take),
      .wdata ({i_addr, i_data}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );
`else
   // Single-entry: accept only while idle, latch straight from the port.
   assign o_ready   = (state_reg == IDLE) && !rst;
   assign req_avail = i_valid && o_ready;
   assign src_req   = '{addr: i_addr, data: i_data};
   assign o_busy    = (state_reg != IDLE);
`endif

   // State and shared counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic; each timed phase lasts (load value + 1) cycles.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      take       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_avail) begin
               state_next = ADDR;
               cnt_next   = PULSE_LD;
               take       = 1'b1;
            end
         end
         ADDR: begin
            if (cnt_reg == '0) begin
               state_next = AWAIT;
               cnt_next   = AWAIT_LD;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         AWAIT: begin
            if (cnt_reg == '0) begin
               state_next = DATA;
               cnt_next   = PULSE_LD;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         DATA: begin
            if (cnt_reg == '0) begin
               state_next = DWAIT;
               cnt_next   = DWAIT_LD;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         DWAIT: begin
            if (cnt_reg == '0) begin
               // Chain straight into the next address write when one is queued.
               if (req_avail) begin
                  state_next = ADDR;
                  cnt_next   = PULSE_LD;
                  take       = 1'b1;
               end else begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Bus values for the next cycle; din/a0 only move on the edge WR rises.
   always_comb begin
      data_next = data_reg;
      din_next  = din_reg;
      a0_next   = a0_reg;
      wr_next   = (state_next == ADDR) || (state_next == DATA);
      if (take) begin
         data_next = src_req.data;
         din_next  = src_req.addr;
         a0_next   = 1'b0;
      end else if ((state_reg == AWAIT) && (state_next == DATA)) begin
         din_next = data_reg;
         a0_next  = 1'b1;
      end
   end

   // Registered bus outputs and latched data byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_reg <= '0;
         din_reg  <= '0;
         a0_reg   <= 1'b0;
         wr_reg   <= 1'b0;
      end else begin
         data_reg <= data_next;
         din_reg  <= din_next;
         a0_reg   <= a0_next;
         wr_reg   <= wr_next;
      end
   end

   assign o_din = din_reg;
   assign o_a0  = a0_reg;
   assign o_wr  = wr_reg;

endmodule

// File: tb/tb_opll_reg_writer.sv
// Self-checking bench for opll_reg_writer (default timing plus a 1/1/1
// timing instance). Works in both the FIFO and single-entry builds.
module tb_opll_reg_writer;
   import opll_reg_writer_pkg::*;

`ifdef OPLL_REG_WRITER_FIFO_EN
   localparam int SPACING = 100;
   localparam int HELD_WAIT = 0;
`else
   localparam int SPACING = 101;
   localparam int HELD_WAIT = 100;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_valid = 1'b0;
   logic [7:0] i_addr = '0;
   logic [7:0] i_data = '0;
   logic       o_ready, o_a0, o_wr, o_busy;
   logic [7:0] o_din;

   logic       m_valid = 1'b0;
   logic [7:0] m_addr = '0;
   logic [7:0] m_data = '0;
   logic       m_ready, m_a0, m_wr, m_busy;
   logic [7:0] m_din;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mon_cmp = 0;
   int mon_err = 0;
   int n_push = 0;
   int n_data = 0;

   req_t       exp_q[$];
   int         starts[$];
   req_t       e;
   logic       prev_wr = 1'b0;
   logic       prev_a0 = 1'b0;
   logic [7:0] prev_din = '0;
   logic [7:0] cur_addr = '0;
   logic       have_addr = 1'b0;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp_adin;
      logic [7:0] exp_ddin;
   } vec_t;
   vec_t vecs[4];

   opll_reg_writer #(
      .WR_PULSE(2), .ADDR_WAIT(12), .DATA_WAIT(84), .FIFO_DEPTH(4)
   ) u_dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_addr(i_addr), .i_data(i_data), .o_din(o_din), .o_a0(o_a0),
      .o_wr(o_wr), .o_busy(o_busy)
   );

   opll_reg_writer #(
      .WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1), .FIFO_DEPTH(4)
   ) u_min (
      .clk(clk), .rst(rst), .i_valid(m_valid), .o_ready(m_ready),
      .i_addr(m_addr), .i_data(m_data), .o_din(m_din), .o_a0(m_a0),
      .o_wr(m_wr), .o_busy(m_busy)
   );

   always #5 clk = ~clk;

   // Scoreboard push on accept edges; protocol monitor on falling edges.
   always @(posedge clk or negedge clk) begin
      if (clk) begin
         cyc++;
         if (!rst && i_valid && o_ready) begin
            exp_q.push_back('{addr: i_addr, data: i_data});
            n_push++;
         end
      end else if (rst) begin
         exp_q.delete();
         starts.delete();
         prev_wr = 1'b0;
         have_addr = 1'b0;
      end else begin
         if (o_wr && prev_wr) begin
            mon_cmp++;
            if (o_din !== prev_din || o_a0 !== prev_a0) begin
               mon_err++;
               $display("FAIL bus_stable din=%02h a0=%0b required din=%02h a0=%0b",
                        o_din, o_a0, prev_din, prev_a0);
            end
         end
         if (o_wr && !prev_wr) begin
            if (!o_a0) begin
               starts.push_back(cyc);
               cur_addr = o_din;
               have_addr = 1'b1;
            end else begin
               n_data++;
               mon_cmp++;
               if (exp_q.size() == 0 || !have_addr) begin
                  mon_err++;
                  $display("FAIL sb_unexpected addr=%02h data=%02h required no write",
                           cur_addr, o_din);
               end else begin
                  e = exp_q.pop_front();
                  if (cur_addr !== e.addr || o_din !== e.data) begin
                     mon_err++;
                     $display("FAIL sb_order addr=%02h data=%02h required addr=%02h data=%02h",
                              cur_addr, o_din, e.addr, e.data);
                  end
               end
               have_addr = 1'b0;
            end
         end
         prev_wr = o_wr;
         prev_din = o_din;
         prev_a0 = o_a0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Present one request and hold it until accepted; waited = ready-low cycles.
   task automatic send(input logic [7:0] a, input logic [7:0] d,
                       output int acc_cyc, output int waited);
      int n = 0;
      i_valid = 1'b1;
      i_addr = a;
      i_data = d;
      @(negedge clk);
      while (o_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      acc_cyc = -1;
      if (n >= 400) begin
         chk("send_timeout", o_ready, 1);
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
      end
      waited = n;
      i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (o_busy !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, o_busy, 0);
   endtask

   // Check the full 100-cycle bus pattern of one solo transaction.
   task automatic run_pattern(input string name, input logic [7:0] adin, input logic [7:0] ddin);
      int n = 0;
      int first_bad = -1;
      logic ew, ea;
      logic [7:0] ed;
      @(negedge clk);
      while (o_wr !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_start"}, o_wr, 1);
      for (int c = 0; c < 100; c++) begin
         if (c < 2)       begin ew = 1'b1; ea = 1'b0; ed = adin; end
         else if (c < 14) begin ew = 1'b0; ea = 1'b0; ed = adin; end
         else if (c < 16) begin ew = 1'b1; ea = 1'b1; ed = ddin; end
         else             begin ew = 1'b0; ea = 1'b1; ed = ddin; end
         if (first_bad < 0 && (o_wr !== ew || o_a0 !== ea || o_din !== ed || o_busy !== 1'b1))
            first_bad = c;
         @(negedge clk);
      end
      chk({name, "_first_bad_cycle"}, first_bad, 32'hFFFF_FFFF);
      chk({name, "_busy_end"}, o_busy, 0);
   endtask

   initial begin
      int acc, w, n, n0, np0, nd0, gap;
      int accs[6];
      logic [3:0] wr_pat, a0_pat;
      int din_err;

      vecs[0] = '{8'h10, 8'h5A, 8'h10, 8'h5A};
      vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{8'h38, 8'hA5, 8'h38, 8'hA5};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_wr", o_wr, 0);
      chk("rst_a0", o_a0, 0);
      chk("rst_din", o_din, 8'h00);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_ready, 0);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", o_ready, 1);

      // Table of solo writes.
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].addr, vecs[i].data, acc, w);
         run_pattern($sformatf("vec%0d", i), vecs[i].exp_adin, vecs[i].exp_ddin);
      end

      // Reset in the middle of the address pulse.
      send(8'h77, 8'h88, acc, w);
      n = 0;
      @(negedge clk);
      while (o_wr !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("midpulse_wr_before", o_wr, 1);
      #2 rst = 1'b1;
      #1;
      chk("midpulse_wr_async", o_wr, 0);
      chk("midpulse_din_async", o_din, 8'h00);
      @(negedge clk);
      #2 rst = 1'b0;

      // Reset in DWAIT, with a request presented while reset is high.
      send(8'h21, 8'h43, acc, w);
      n = 0;
      @(negedge clk);
      while (o_wr !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      repeat (30) @(negedge clk);
      chk("dwait_a0_before", o_a0, 1);
      #2 rst = 1'b1;
      #1;
      chk("dwait_rst_wr", o_wr, 0);
      chk("dwait_rst_a0", o_a0, 0);
      chk("dwait_rst_din", o_din, 8'h00);
      chk("dwait_rst_busy", o_busy, 0);
      np0 = n_push;
      i_valid = 1'b1;
      i_addr = 8'hEE;
      i_data = 8'hDD;
      repeat (3) @(negedge clk);
      chk("rst_ready_forced_low", o_ready, 0);
      i_valid = 1'b0;
      #2 rst = 1'b0;
      chk("rst_requests_dropped", n_push - np0, 0);
      @(negedge clk);
      chk("release_ready_first_cycle", o_ready, 1);
      chk("release_busy", o_busy, 0);
      send(8'h44, 8'h99, acc, w);
      run_pattern("after_rst", 8'h44, 8'h99);

      // i_valid held across a transaction: spacing of ADDR phases.
      n0 = starts.size();
      send(8'h51, 8'h61, acc, w);
      send(8'h52, 8'h62, acc, w);
      chk("held_ready_low_cycles", w, HELD_WAIT);
      n = 0;
      while (starts.size() < n0 + 2 && n < 300) begin @(negedge clk); n++; end
      chk("held_starts_seen", starts.size() >= n0 + 2, 1);
      if (starts.size() >= n0 + 2)
         chk("held_spacing", starts[n0+1] - starts[n0], SPACING);
      wait_idle("held_idle");

`ifdef OPLL_REG_WRITER_FIFO_EN
      // Six back-to-back requests into a four-entry queue.
      n0 = starts.size();
      for (int i = 0; i < 6; i++) begin
         send(8'h30 + 8'(i), 8'hC0 + 8'(i), accs[i], w);
      end
      for (int i = 1; i < 5; i++)
         chk($sformatf("fifo_accept_%0d", i), accs[i] - accs[0], i);
      chk("fifo_accept_5", accs[5] - accs[0], 102);
      n = 0;
      while (starts.size() < n0 + 6 && n < 800) begin @(negedge clk); n++; end
      chk("fifo_starts_seen", starts.size() >= n0 + 6, 1);
      if (starts.size() >= n0 + 6)
         for (int i = 1; i < 6; i++)
            chk($sformatf("fifo_spacing_%0d", i), starts[n0+i] - starts[n0+i-1], 100);
      wait_idle("fifo_idle");
`else
      accs[0] = 0;
`endif

      // Minimum timing instance: 4-cycle transaction.
      m_addr = 8'h2B;
      m_data = 8'hC4;
      m_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (m_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 m_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (m_wr !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      wr_pat = '0;
      a0_pat = '0;
      din_err = 0;
      for (int c = 0; c < 4; c++) begin
         wr_pat = {wr_pat[2:0], m_wr};
         a0_pat = {a0_pat[2:0], m_a0};
         if (m_din !== ((c < 2) ? 8'h2B : 8'hC4)) din_err++;
         @(negedge clk);
      end
      chk("min_wr_pattern", wr_pat, 4'b1010);
      chk("min_a0_pattern", a0_pat, 4'b0011);
      chk("min_din_errors", din_err, 0);
      chk("min_busy_end", m_busy, 0);

      // Random stream through the scoreboard and protocol monitor.
      np0 = n_push;
      nd0 = n_data;
      for (int i = 0; i < 200; i++) begin
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), acc, w);
      end
      wait_idle("random_idle");
      chk("random_pushed", n_push - np0, 200);
      chk("random_written", n_data - nd0, 200);
      chk("sb_queue_empty", exp_q.size(), 0);
      chk("monitor_errors", mon_err, 0);

      checks = checks + mon_cmp;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
